// File: rtl/issue_ctrl_if.sv
// Issue-stage bundle: instruction queue, register-file/rename lookup, ROB
// status and dispatch packet. The slave modport is the issue controller side.
interface issue_ctrl_if #(
   parameter int unsigned ROB_W = 4
) ();
   logic             rdy;
   logic             iq_valid;
   logic [4:0]       iq_rs1;
   logic [4:0]       iq_rs2;
   logic [4:0]       iq_rd;
   logic [31:0]      iq_payload;
   logic             iq_ready;
   logic [4:0]       reg_rs1;
   logic [4:0]       reg_rs2;
   logic [31:0]      reg_rs1_val;
   logic [31:0]      reg_rs2_val;
   logic             reg_rs1_rdy;
   logic             reg_rs2_rdy;
   logic             reg_sgn;
   logic [4:0]       reg_rd;
   logic [ROB_W-1:0] reg_rob_name;
   logic             reg_flush;
   logic             rs_full;
   logic             rob_commit;
   logic             flush;
   logic             dis_valid;
   logic [ROB_W-1:0] dis_rob_id;
   logic [31:0]      dis_rs1_val;
   logic [31:0]      dis_rs2_val;
   logic             dis_rs1_rdy;
   logic             dis_rs2_rdy;
   logic [4:0]       dis_rd;
   logic [31:0]      dis_payload;

   modport slave (
      input  rdy, iq_valid, iq_rs1, iq_rs2, iq_rd, iq_payload,
      input  reg_rs1_val, reg_rs2_val, reg_rs1_rdy, reg_rs2_rdy,
      input  rs_full, rob_commit, flush,
      output iq_ready, reg_rs1, reg_rs2, reg_sgn, reg_rd, reg_rob_name, reg_flush,
      output dis_valid, dis_rob_id, dis_rs1_val, dis_rs2_val,
      output dis_rs1_rdy, dis_rs2_rdy, dis_rd, dis_payload
   );

   modport master (
      output rdy, iq_valid, iq_rs1, iq_rs2, iq_rd, iq_payload,
      output reg_rs1_val, reg_rs2_val, reg_rs1_rdy, reg_rs2_rdy,
      output rs_full, rob_commit, flush,
      input  iq_ready, reg_rs1, reg_rs2, reg_sgn, reg_rd, reg_rob_name, reg_flush,
      input  dis_valid, dis_rob_id, dis_rs1_val, dis_rs2_val,
      input  dis_rs1_rdy, dis_rs2_rdy, dis_rd, dis_payload
   );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue controller: allocates ROB ids, strobes rename, registers a
// one-cycle-latency dispatch packet and drains for DRAIN_CYC cycles after a flush.
module issue_ctrl #(
   parameter int unsigned ROB_W     = 4,
   parameter int unsigned DRAIN_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   issue_ctrl_if.slave bus
);
   localparam logic [ROB_W:0] DEPTH      = (ROB_W+1)'(1 << ROB_W);
   localparam logic [3:0]     DRAIN_LOAD = 4'(DRAIN_CYC - 1);

   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [ROB_W-1:0] tail_q, tail_d;
   logic [ROB_W:0]   count_q, count_d;
   logic [3:0]       drain_q, drain_d;
   logic             dis_valid_q, dis_valid_d;
   logic             reg_flush_q, reg_flush_d;
   logic [ROB_W-1:0] dis_rob_id_q;
   logic [4:0]       dis_rd_q;
   logic [31:0]      dis_payload_q;
   logic [31:0]      dis_rs1_val_q, dis_rs2_val_q;
   logic             dis_rs1_rdy_q, dis_rs2_rdy_q;
   logic             accept, commit_ok;

   assign accept = bus.rdy && (state_q == RUN) && bus.iq_valid && !bus.flush &&
                   !bus.rs_full && (count_q < DEPTH);
   // Retirement only matters while running with something outstanding.
   assign commit_ok = bus.rob_commit && (state_q == RUN) && (count_q != '0);

   always_comb begin
      state_d     = state_q;
      tail_d      = tail_q;
      count_d     = count_q;
      drain_d     = drain_q;
      dis_valid_d = dis_valid_q;
      reg_flush_d = reg_flush_q;
      if (bus.rdy) begin
         reg_flush_d = bus.flush;
         if (bus.flush) begin
            state_d     = DRAIN;
            drain_d     = DRAIN_LOAD;
            tail_d      = '0;
            count_d     = '0;
            dis_valid_d = 1'b0;
         end else begin
            dis_valid_d = accept;
            if (accept) tail_d = tail_q + ROB_W'(1);
            if (accept && !commit_ok)
               count_d = count_q + (ROB_W+1)'(1);
            else if (commit_ok && !accept)
               count_d = count_q - (ROB_W+1)'(1);
            if (state_q == DRAIN) begin
               if (drain_q == '0) state_d = RUN;
               else               drain_d = drain_q - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         tail_q        <= '0;
         count_q       <= '0;
         drain_q       <= '0;
         dis_valid_q   <= 1'b0;
         reg_flush_q   <= 1'b0;
         dis_rob_id_q  <= '0;
         dis_rd_q      <= '0;
         dis_payload_q <= '0;
         dis_rs1_val_q <= '0;
         dis_rs2_val_q <= '0;
         dis_rs1_rdy_q <= 1'b0;
         dis_rs2_rdy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         drain_q     <= drain_d;
         dis_valid_q <= dis_valid_d;
         reg_flush_q <= reg_flush_d;
         if (accept) begin
            dis_rob_id_q  <= tail_q;
            dis_rd_q      <= bus.iq_rd;
            dis_payload_q <= bus.iq_payload;
            dis_rs1_val_q <= bus.reg_rs1_val;
            dis_rs2_val_q <= bus.reg_rs2_val;
            dis_rs1_rdy_q <= bus.reg_rs1_rdy;
            dis_rs2_rdy_q <= bus.reg_rs2_rdy;
         end
      end
   end

   assign bus.reg_rs1      = bus.iq_rs1;
   assign bus.reg_rs2      = bus.iq_rs2;
   assign bus.iq_ready     = accept;
   assign bus.reg_sgn      = accept;
   assign bus.reg_rd       = bus.iq_rd;
   assign bus.reg_rob_name = tail_q;
   assign bus.reg_flush    = reg_flush_q;
   assign bus.dis_valid    = dis_valid_q;
   assign bus.dis_rob_id   = dis_rob_id_q;
   assign bus.dis_rd       = dis_rd_q;
   assign bus.dis_payload  = dis_payload_q;
   assign bus.dis_rs1_val  = dis_rs1_val_q;
   assign bus.dis_rs2_val  = dis_rs2_val_q;
   assign bus.dis_rs1_rdy  = dis_rs1_rdy_q;
   assign bus.dis_rs2_rdy  = dis_rs2_rdy_q;
endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 The module SHALL have parameter ROB_W, default 4, meaning log2 of ROB depth (ROB ids 0..2^ROB_W-1).
REQ-002 The module SHALL have parameter DRAIN_CYC, default 2, meaning the number of idle cycles after a flush before dispatch resumes (range 1..15).
REQ-003 The module SHALL have these ports, one per line (name, direction, width, meaning); clock and reset are decided as one clock with asynchronous, active-high reset:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; low freezes all state.
- iq_valid  in  1  decoded instruction available.
- iq_rs1, iq_rs2, iq_rd  in  5 each  register fields.
- iq_payload  in  32  opaque decoded info.
- iq_ready  out  1  instruction accepted this cycle.
- reg_rs1, reg_rs2  out  5 each  register-file lookup indices.
- reg_rs1_val, reg_rs2_val  in  32 each  operand value or producer ROB id.
- reg_rs1_rdy, reg_rs2_rdy  in  1 each  operand ready.
- reg_sgn  out  1  rename write strobe.
- reg_rd  out  5  rename destination.
- reg_rob_name  out  ROB_W  ROB id being allocated.
- reg_flush  out  1  clear all rename tags.
- rs_full  in  1  reservation station cannot accept.
- rob_commit  in  1  ROB head retired one entry.
- flush  in  1  mispredict; squash everything in flight.
- dis_valid  out  1  dispatch packet valid.
- dis_rob_id  out  ROB_W  allocated ROB id.
- dis_rs1_val, dis_rs2_val  out  32 each  captured operands or tags.
- dis_rs1_rdy, dis_rs2_rdy  out  1 each  captured readiness.
- dis_rd  out  5  destination register.
- dis_payload  out  32  captured iq_payload.

Function
REQ-004 The block SHALL implement states RUN and DRAIN.
REQ-005 reg_rs1/reg_rs2 SHALL combinationally equal iq_rs1/iq_rs2 at all times.
REQ-006 accept SHALL be the combinational AND of: rdy, state==RUN, iq_valid, !flush, !rs_full, and count<2^ROB_W.
REQ-007 iq_ready and reg_sgn SHALL equal accept; reg_rd=iq_rd; reg_rob_name=tail.
REQ-008 On an accept edge, the dis_* registers SHALL capture tail, iq_rd, iq_payload and the reg_* operand value/rdy, giving dis_valid=1 the next cycle (1-cycle latency).
REQ-009 On a non-accept edge with rdy=1, dis_valid SHALL be 0.
REQ-010 tail SHALL increment mod 2^ROB_W on each accept; wrap 2^ROB_W-1 -> 0.
REQ-011 count SHALL be ROB_W+1 bits wide: +1 on accept only, -1 on rob_commit only, and unchanged when both occur together.
REQ-012 rob_commit at count==0 SHALL be ignored, with count saturating at 0.
REQ-013 When flush=1 with rdy=1 (priority over all else), the next state SHALL be: tail=0, count=0, dis_valid=0, state=DRAIN, drain counter=DRAIN_CYC-1; the flush-cycle rob_commit is discarded.
REQ-014 reg_flush SHALL be asserted exactly the cycle after flush is sampled, as a registered 1-cycle pulse.
REQ-015 In DRAIN, the counter SHALL decrement each rdy cycle, and state SHALL move to RUN on the edge where the counter is 0.
REQ-016 A flush during DRAIN SHALL reload the counter and re-pulse reg_flush.
REQ-017 rob_commit in DRAIN SHALL be ignored.
REQ-018 When rdy=0, all registers SHALL hold and reg_sgn/iq_ready SHALL be 0; a flush sampled while rdy=0 SHALL be lost.

Reset
REQ-019 While rst=1 (asynchronously): state=RUN, tail=0, count=0, drain counter=0, dis_valid=0, reg_flush=0, dis_rob_id=0, dis_rd=0, and dis_rs*_val/rdy/payload=0.
REQ-020 Reset asserted mid-DRAIN or mid-dispatch SHALL abort immediately, with the first accept after release allocating ROB id 0.

Verification
REQ-021 Reset release, iq_valid=1 for 3 cycles, rs_full=0 -> reg_sgn high 3 cycles with reg_rob_name 0,1,2; dis_valid high the following 3 cycles with dis_rob_id 0,1,2.
REQ-022 ROB_W=4, 16 accepts with no commits -> 17th cycle iq_ready=0, count=16; single rob_commit -> next cycle accept with rob id 0 (wrap).
REQ-023 count=5, rob_commit and accept in the same cycle -> count stays 5, tail +1.
REQ-024 flush with count=7, tail=9 -> next cycle reg_flush=1, dis_valid=0, count=0; iq_ready=0 for DRAIN_CYC=2 cycles, then first accept gets rob id 0.
REQ-025 rdy=0 for 4 cycles with iq_valid=1 -> no reg_sgn and all outputs hold; on rdy=1, dispatch resumes with the next sequential id.
REQ-026 reg_rs1_rdy=0, reg_rs1_val=0x3 (tag) at accept -> dis_rs1_rdy=0, dis_rs1_val=0x3.
